// File: rtl/instr_dispatch_pkg.sv
// rtl/instr_dispatch_pkg.sv - shared states, opcode classes and class decode for instr_dispatch
//
// Purpose : sequencer state encoding, opcode-class constants and the
//           opcode-to-class decode used by the dispatch FSM.
// Ports   : none (package).
package instr_dispatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC_ALU = 3'd3,
        S_EXEC_MOV = 3'd4,
        S_EXEC_LS  = 3'd5,
        S_HALT     = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_MOV  = 3'd1,
        CLS_LS   = 3'd2,
        CLS_HALT = 3'd3,
        CLS_ALU  = 3'd4
    } op_class_t;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_MOV_LO = 4'b0001;
    localparam logic [3:0] OP_MOV_HI = 4'b0011;
    localparam logic [3:0] OP_LS_LO  = 4'b0100;
    localparam logic [3:0] OP_LS_HI  = 4'b0111;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_ALU_LO = 4'b1001;
    localparam logic [3:0] OP_ALU_HI = 4'b1111;

    // Ranges are contiguous, so each test only needs the upper bound once
    // NOP and HALT have been peeled off.
    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        if (op == OP_NOP)
            cls = CLS_NOP;
        else if (op == OP_HALT)
            cls = CLS_HALT;
        else if (op <= OP_MOV_HI)
            cls = CLS_MOV;
        else if (op <= OP_LS_HI)
            cls = CLS_LS;
        else
            cls = CLS_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/instr_dispatch_watchdog.sv
// rtl/instr_dispatch_watchdog.sv - per-phase watchdog counter with expiry flag
//
// Purpose : counts cycles spent in a supervised phase; flags expiry on the
//           cycle the count reaches TIMEOUT-1 while enabled.
// Ports   : clk       - clock, rising edge
//           rst       - synchronous active-high reset
//           i_clear   - restart the count at 0 (phase entry)
//           i_enable  - a supervised phase is active; count this cycle
//           o_expired - enabled and count == TIMEOUT-1
module dispatch_watchdog
    import instr_dispatch_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - top-level fetch/decode/dispatch sequencer
//
// Purpose : drives fetch, decodes the opcode, hands control to one execution
//           FSM, waits for its done pulse, counts retirements, and guards
//           each FETCH/EXEC phase with a watchdog.
// Option  : DISPATCH_SINGLE_STEP_EN adds input step; one instruction per step.
// Ports   : clk, rst (sync active-high), run (level)
//           fullBitNum[15:0] - instruction register, [15:12] opcode
//           fetch_done, alu_done, mov_done, ls_done - done pulses
//           step             - single-step pulse (option only)
//           IF_active, alu_go, mov_go, ls_go - phase enables
//           busy, halted, fault - status; instr_count[CNT_W-1:0] - retired
module instr_dispatch
    import instr_dispatch_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [15:0]      fullBitNum,
    input  logic             fetch_done,
    input  logic             alu_done,
    input  logic             mov_done,
    input  logic             ls_done,
`ifdef DISPATCH_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             IF_active,
    output logic             alu_go,
    output logic             mov_go,
    output logic             ls_go,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_opcode;
    logic [CNT_W-1:0] r_count;
    logic            w_retire;
    logic            w_leave_idle;
    state_t          w_after_retire;
    logic            w_exec_done;
    logic            w_wd_en;
    logic            w_wd_clr;
    logic            w_wd_expired;
    op_class_t       w_dec_class;
    logic            w_unused_operand;

    assign w_unused_operand = ^fullBitNum[11:0];

`ifdef DISPATCH_SINGLE_STEP_EN
    assign w_leave_idle   = run && step;
    assign w_after_retire = S_IDLE;
`else
    assign w_leave_idle   = run;
    assign w_after_retire = run ? S_FETCH : S_IDLE;
`endif

    assign w_dec_class = op_class(fullBitNum[15:12]);

    // The latched opcode picks which done pulse counts; pulses from the
    // other execution FSMs are thereby ignored.
    always_comb begin
        w_exec_done = 1'b0;
        case (op_class(r_opcode))
            CLS_ALU: w_exec_done = alu_done;
            CLS_MOV: w_exec_done = mov_done;
            CLS_LS:  w_exec_done = ls_done;
            default: w_exec_done = 1'b0;
        endcase
    end

    assign w_wd_en = (r_state == S_FETCH) || (r_state == S_EXEC_ALU) ||
                     (r_state == S_EXEC_MOV) || (r_state == S_EXEC_LS);

    // Restart the watchdog on every entry into a supervised phase, including
    // EXEC -> FETCH, but not while staying in the same phase.
    assign w_wd_clr = (w_state_nxt != r_state) &&
                      ((w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC_ALU) ||
                       (w_state_nxt == S_EXEC_MOV) || (w_state_nxt == S_EXEC_LS));

    dispatch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clr),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Done is tested before expiry so a done on the last allowed cycle wins.
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_leave_idle)
                    w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_done)
                    w_state_nxt = S_DECODE;
                else if (w_wd_expired)
                    w_state_nxt = S_FAULT;
            end
            S_DECODE: begin
                case (w_dec_class)
                    CLS_NOP: begin
                        w_retire    = 1'b1;
                        w_state_nxt = w_after_retire;
                    end
                    CLS_HALT: begin
                        w_retire    = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                    CLS_MOV: w_state_nxt = S_EXEC_MOV;
                    CLS_LS:  w_state_nxt = S_EXEC_LS;
                    default: w_state_nxt = S_EXEC_ALU;
                endcase
            end
            S_EXEC_ALU, S_EXEC_MOV, S_EXEC_LS: begin
                if (w_exec_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = w_after_retire;
                end else if (w_wd_expired) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_opcode <= 4'b0000;
        else if (r_state == S_DECODE)
            r_opcode <= fullBitNum[15:12];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (w_retire)
            r_count <= r_count + 1'b1;
    end

    assign IF_active   = (r_state == S_FETCH);
    assign alu_go      = (r_state == S_EXEC_ALU);
    assign mov_go      = (r_state == S_EXEC_MOV);
    assign ls_go       = (r_state == S_EXEC_LS);
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
    assign halted      = (r_state == S_HALT);
    assign fault       = (r_state == S_FAULT);
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_dispatch.sv
// tb/tb_instr_dispatch.sv - directed self-checking bench for instr_dispatch
module tb_instr_dispatch;

    localparam int TB_CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, fetch_done, alu_done, mov_done, ls_done;
    logic [15:0] fullBitNum;
`ifdef DISPATCH_SINGLE_STEP_EN
    logic        step;
`endif
    logic        IF_active, alu_go, mov_go, ls_go, busy, halted, fault;
    logic [TB_CNT_W-1:0] instr_count;
    logic [2:0]  go_vec;

    assign go_vec = {alu_go, mov_go, ls_go};

    instr_dispatch #(
        .TIMEOUT (32),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .fullBitNum  (fullBitNum),
        .fetch_done  (fetch_done),
        .alu_done    (alu_done),
        .mov_done    (mov_done),
        .ls_done     (ls_done),
`ifdef DISPATCH_SINGLE_STEP_EN
        .step        (step),
`endif
        .IF_active   (IF_active),
        .alu_go      (alu_go),
        .mov_go      (mov_go),
        .ls_go       (ls_go),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        run        = 1'b0;
        fetch_done = 1'b0;
        alu_done   = 1'b0;
        mov_done   = 1'b0;
        ls_done    = 1'b0;
        fullBitNum = 16'h0000;
`ifdef DISPATCH_SINGLE_STEP_EN
        step       = 1'b0;
`endif
        tick;
        rst = 1'b0;
    endtask

    // From a FETCH cycle: deliver the instruction, pass DECODE, land in the next state.
    task automatic decode_to_exec(input logic [15:0] instr);
        fetch_done = 1'b1;
        fullBitNum = instr;
        tick;
        fetch_done = 1'b0;
        tick;
    endtask

    logic status_all;
    logic ok;

    initial begin
        do_reset;
        status_all = IF_active | alu_go | mov_go | ls_go | busy | halted | fault;
        check("reset_flags", {31'd0, status_all}, 32'd0);
        check("reset_count", {28'd0, instr_count}, 32'd0);

`ifdef DISPATCH_SINGLE_STEP_EN
        run = 1'b1;
        tick;
        tick;
        check("step_idle_hold", {30'd0, busy, IF_active}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick;
            step = 1'b0;
            check("step_fetch", {31'd0, IF_active}, 32'd1);
            step       = 1'b1;
            fetch_done = 1'b1;
            fullBitNum = 16'h1000;
            tick;
            step       = 1'b0;
            fetch_done = 1'b0;
            tick;
            check("step_mov_go", {29'd0, go_vec}, 32'b010);
            mov_done = 1'b1;
            tick;
            mov_done = 1'b0;
            check("step_back_idle", {30'd0, busy, IF_active}, 32'd0);
        end
        tick;
        tick;
        check("step_count3", {28'd0, instr_count}, 32'd3);
`else
        // Basic ALU instruction timeline.
        run = 1'b1;
        tick;
        check("t1_if_c1", {31'd0, IF_active}, 32'd1);
        tick;
        tick;
        check("t1_if_c3", {31'd0, IF_active}, 32'd1);
        fetch_done = 1'b1;
        fullBitNum = 16'h9042;
        tick;
        fetch_done = 1'b0;
        check("t1_decode", {29'd0, busy, IF_active, |go_vec}, 32'b100);
        tick;
        check("t1_alu_go", {29'd0, go_vec}, 32'b100);
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick;
            if (go_vec !== 3'b100) ok = 1'b0;
        end
        check("t1_alu_go_hold", {31'd0, ok}, 32'd1);
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        check("t1_refetch", {28'd0, IF_active, go_vec}, 32'b1000);
        check("t1_count", {28'd0, instr_count}, 32'd1);

        // NOP, MOV, LS sequence.
        do_reset;
        run = 1'b1;
        tick;
        fetch_done = 1'b1;
        fullBitNum = 16'h0000;
        tick;
        fetch_done = 1'b0;
        check("t2_nop_decode_go", {29'd0, go_vec}, 32'd0);
        tick;
        check("t2_nop_refetch", {28'd0, IF_active, go_vec}, 32'b1000);
        check("t2_nop_count", {28'd0, instr_count}, 32'd1);
        decode_to_exec(16'h1083);
        check("t2_mov_go", {29'd0, go_vec}, 32'b010);
        alu_done   = 1'b1;
        ls_done    = 1'b1;
        fetch_done = 1'b1;
        tick;
        alu_done   = 1'b0;
        ls_done    = 1'b0;
        fetch_done = 1'b0;
        check("t2_foreign_done_ignored", {25'd0, go_vec, instr_count}, {25'd0, 3'b010, 4'd1});
        mov_done = 1'b1;
        tick;
        mov_done = 1'b0;
        check("t2_mov_retire", {27'd0, IF_active, instr_count}, {27'd0, 1'b1, 4'd2});
        decode_to_exec(16'h4005);
        check("t2_ls_go", {29'd0, go_vec}, 32'b001);
        ls_done = 1'b1;
        tick;
        ls_done = 1'b0;
        check("t2_ls_retire", {27'd0, IF_active, instr_count}, {27'd0, 1'b1, 4'd3});

        // HALT is sticky until reset.
        do_reset;
        run = 1'b1;
        tick;
        decode_to_exec(16'h8000);
        check("t3_halt", {29'd0, halted, busy, IF_active}, 32'b100);
        check("t3_halt_count", {28'd0, instr_count}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            run        = i[0];
            fetch_done = 1'b1;
            alu_done   = ~i[0];
            tick;
        end
        fetch_done = 1'b0;
        alu_done   = 1'b0;
        check("t3_halt_sticky", {26'd0, halted, busy, instr_count}, {26'd0, 1'b1, 1'b0, 4'd1});
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t3_halt_cleared", {31'd0, halted}, 32'd0);

        // Watchdog expiry in EXEC_ALU: entry is E0, fault visible at E32.
        do_reset;
        run = 1'b1;
        tick;
        decode_to_exec(16'h9000);
        for (int i = 0; i < 31; i++) tick;
        check("t4_no_fault_e31", {30'd0, fault, alu_go}, 32'b01);
        tick;
        check("t4_fault_e32", {29'd0, fault, busy, alu_go}, 32'b100);
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        check("t4_fault_frozen", {27'd0, fault, instr_count}, {27'd0, 1'b1, 4'd0});

        // Done on the last allowed cycle beats expiry.
        do_reset;
        run = 1'b1;
        tick;
        decode_to_exec(16'h9000);
        for (int i = 0; i < 31; i++) tick;
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        check("t4_done_wins", {26'd0, fault, IF_active, instr_count}, {26'd0, 1'b0, 1'b1, 4'd1});

        // Watchdog in FETCH.
        do_reset;
        run = 1'b1;
        tick;
        for (int i = 0; i < 31; i++) tick;
        check("t4_fetch_no_fault", {30'd0, fault, IF_active}, 32'b01);
        tick;
        check("t4_fetch_fault", {30'd0, fault, IF_active}, 32'b10);

        // run dropped during EXEC_LS.
        do_reset;
        run = 1'b1;
        tick;
        decode_to_exec(16'h4005);
        run = 1'b0;
        tick;
        tick;
        check("t5_ls_continues", {29'd0, go_vec}, 32'b001);
        ls_done = 1'b1;
        tick;
        ls_done = 1'b0;
        check("t5_idle", {25'd0, IF_active, busy, go_vec[0], instr_count}, {25'd0, 3'b000, 4'd1});
        tick;
        check("t5_idle_hold", {31'd0, IF_active}, 32'd0);
        run = 1'b1;
        tick;
        check("t5_resume", {31'd0, IF_active}, 32'd1);

        // Reset mid EXEC_MOV.
        decode_to_exec(16'h2000);
        check("t5_mov_go", {29'd0, go_vec}, 32'b010);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        status_all = IF_active | alu_go | mov_go | ls_go | busy | halted | fault;
        check("t5_rst_flags", {31'd0, status_all}, 32'd0);
        check("t5_rst_count", {28'd0, instr_count}, 32'd0);

        // Counter wrap with a 4-bit counter.
        do_reset;
        run = 1'b1;
        tick;
        for (int i = 0; i < 17; i++) begin
            fetch_done = 1'b1;
            fullBitNum = 16'h0000;
            tick;
            fetch_done = 1'b0;
            tick;
            if (i == 15) check("t6_wrap_zero", {28'd0, instr_count}, 32'd0);
        end
        check("t6_wrap_one", {28'd0, instr_count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Top-level instruction sequencer for the microcontroller.
- Drives the fetch phase, decodes the opcode of the fetched instruction, and hands control to exactly one execution FSM (ALU, move, load/store).
- Waits for that FSM's done pulse, then returns to fetch.
- Provides a per-phase watchdog, halt handling and a retired-instruction counter.

Parameters:
- TIMEOUT, default 32: maximum cycles allowed in any FETCH or EXEC state before faulting.
- CNT_W, default 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; allow execution to start and continue.
- fullBitNum  in  16  instruction register contents; [15:12] is the opcode.
- fetch_done  in  1  one-cycle pulse from the fetch FSM.
- alu_done  in  1  one-cycle pulse from the ALU FSM.
- mov_done  in  1  one-cycle pulse from the move FSM.
- ls_done  in  1  one-cycle pulse from the load/store FSM.
- IF_active  out  1  fetch phase active; also holds the execution FSMs in their idle state.
- alu_go  out  1  level; ALU FSM may run.
- mov_go  out  1  level; move FSM may run.
- ls_go  out  1  level; load/store FSM may run.
- busy  out  1  high when not in IDLE, HALT or FAULT.
- halted  out  1  HALT opcode executed.
- fault  out  1  watchdog expired.
- instr_count  out  CNT_W  count of retired instructions; wraps.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; all outputs 0; watchdog=0; instr_count=0; opcode register=0.
- Outputs are Moore, decoded from the registered state. No output depends combinationally on any input.
- Opcode classes:
  - 0000 NOP
  - 0001–0011 MOV
  - 0100–0111 LS
  - 1000 HALT
  - 1001–1111 ALU
- IDLE: all go signals 0. Move to FETCH on the next edge when run=1.
- FETCH: IF_active=1. On fetch_done, move to DECODE.
- DECODE: lasts exactly 1 cycle.
  - Latch fullBitNum[15:12] into the opcode register.
  - NOP: instr_count+1, then FETCH if run=1, else IDLE.
  - HALT: instr_count+1, then HALT.
  - MOV, LS or ALU: go to EXEC_MOV, EXEC_LS or EXEC_ALU respectively.
- EXEC_x: the matching x_go=1; IF_active=0; all other go signals 0.
  - On x_done: instr_count+1, then FETCH if run=1, else IDLE.
- Done pulses not matching the current state are ignored in every state. fetch_done outside FETCH is ignored.
- Latency: one instruction costs (fetch cycles) + 1 (DECODE) + (exec cycles). There is no bubble between done and the next FETCH.
- Watchdog:
  - Cleared on entry to FETCH and every EXEC state; increments each cycle spent in those states.
  - Expiry occurs when the count reaches TIMEOUT-1 and no done is present that cycle. Next state is FAULT.
  - If done and expiry occur in the same cycle, done wins.
- HALT: halted=1, busy=0. Exit only by rst; run is ignored.
- FAULT: fault=1, busy=0. Exit only by rst; instr_count frozen.
- run falling mid-instruction: the current instruction completes, then IDLE. run rising again resumes at FETCH.
- rst mid-operation: immediate return to IDLE with all outputs 0 after that edge.
- instr_count wraps from 2^CNT_W−1 to 0 with no flag.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro DISPATCH_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1-bit pulse).
  - Leaving IDLE requires run=1 AND step=1.
  - After each retirement, the state always returns to IDLE regardless of run, so exactly one instruction executes per step pulse.
  - A step pulse while not in IDLE is ignored.
- When undefined: no step port; behaviour as above.

Decomposition:
- Shared package:
  - State enumeration localparams (IDLE, FETCH, DECODE, EXEC_ALU, EXEC_MOV, EXEC_LS, HALT, FAULT).
  - Opcode-class constants (OP_NOP=4'b0000, OP_HALT=4'b1000, MOV range, LS range, ALU range).
  - Class-decode function.
- One natural sub-module: dispatch_watchdog, holding the clear/enable counter and the expiry flag, parameterised by TIMEOUT.

Test Plan:
- Reset then run=1, fetch_done at cycle 3, instruction 0x9042, alu_done 10 cycles after DECODE → IF_active high cycles 1–3, alu_go high until alu_done, instr_count=1, FETCH re-entered the next cycle.
- Sequence NOP (0x0000), MOV (0x1083), LS (0x4005) with prompt done pulses → only the matching go asserts each time; NOP produces no go signal; instr_count=3.
- HALT 0x8000 → halted=1, busy=0, instr_count=1; further fetch_done/run toggles cause no change until rst.
- TIMEOUT=32 with alu_done withheld → fault=1 exactly 32 cycles after EXEC_ALU entry. Repeat with alu_done on cycle 31 → no fault.
- run dropped during EXEC_LS, ls_done delivered → IDLE, IF_active stays 0; run reasserted → FETCH. Also rst asserted mid-EXEC_MOV → all outputs 0 on the following cycle.
- CNT_W=4, 17 NOPs → instr_count wraps to 1. With DISPATCH_SINGLE_STEP_EN, run=1 and 3 step pulses → exactly 3 instructions retired.
